// File: rtl/idli_ser_alu_m.sv
// idli_ser_alu_m: serial slice-wise ALU with inter-slice carry and word-level flags
package idli_ser_alu_pkg;
  typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_OR, ALU_XOR} alu_op_t;
endpackage

module idli_ser_alu_m
  import idli_ser_alu_pkg::*;
#(
  parameter int SLICE_W = 4,
  parameter int WORD_W = 16
) (
  input  logic               i_alu_gck,
  input  logic               i_alu_rst,
  input  logic               i_alu_vld,
  input  logic               i_alu_first,
  input  alu_op_t            i_alu_op,
  input  logic               i_alu_rhs_inv,
  input  logic               i_alu_cin,
  input  logic [SLICE_W-1:0] i_alu_lhs,
  input  logic [SLICE_W-1:0] i_alu_rhs,
  output logic               o_alu_vld,
  output logic               o_alu_last,
  output logic [SLICE_W-1:0] o_alu_data,
  output logic [3:0]         o_alu_flags,
  output logic               o_alu_busy
);
  localparam int NSLICE = WORD_W / SLICE_W;
  localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic {IDLE, RUN} state_t;

  if (SLICE_W < 1 || WORD_W % SLICE_W != 0 || NSLICE < 1) begin : g_bad_params
    $error("idli_ser_alu_m: WORD_W must be a positive multiple of SLICE_W");
  end

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               cy_q, cy_d, z_q, z_d, inv_q, inv_d;
  alu_op_t            op_q, op_d;
  logic               vld_q, vld_d, last_q, last_d;
  logic [SLICE_W-1:0] data_q, data_d;
  logic [3:0]         flags_q, flags_d;
  logic               first, acc, last, is_add, cin, inv, co, v, zacc;
  alu_op_t            op;
  logic [SLICE_W-1:0] rhs, res;
  logic [SLICE_W:0]   sum;

  // slice datapath, sequencing and next-state; op/inv/cin come straight from the inputs on the first slice
  always_comb begin
    first   = state_q == IDLE;
    acc     = i_alu_vld & (i_alu_first | ~first);
    op      = first ? i_alu_op : op_q;
    inv     = first ? i_alu_rhs_inv : inv_q;
    cin     = first ? i_alu_cin : cy_q;
    rhs     = inv ? ~i_alu_rhs : i_alu_rhs;
    sum     = {1'b0, i_alu_lhs} + {1'b0, rhs} + {{SLICE_W{1'b0}}, cin};
    is_add  = op == ALU_ADD;
    res     = is_add ? sum[SLICE_W-1:0] :
              op == ALU_AND ? i_alu_lhs & rhs :
              op == ALU_OR  ? i_alu_lhs | rhs : i_alu_lhs ^ rhs;
    co      = is_add & sum[SLICE_W];
    v       = is_add & (sum[SLICE_W] ^ sum[SLICE_W-1] ^ i_alu_lhs[SLICE_W-1] ^ rhs[SLICE_W-1]);
    last    = first ? NSLICE == 1 : cnt_q == CW'(NSLICE - 1);
    zacc    = (first | z_q) & ~|res;
    state_d = acc ? (last ? IDLE : RUN) : state_q;
    cnt_d   = acc ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    cy_d    = acc ? co : cy_q;
    z_d     = acc ? zacc : z_q;
    op_d    = acc ? op : op_q;
    inv_d   = acc ? inv : inv_q;
    vld_d   = acc;
    last_d  = acc & last;
    data_d  = acc ? res : '0;
    flags_d = acc & last ? {zacc, res[SLICE_W-1], co, v} : flags_q;
  end

  // state and registered outputs; reset aborts any operation in flight
  always_ff @(posedge i_alu_gck) begin
    if (i_alu_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      z_q     <= 1'b1;
      op_q    <= ALU_ADD;
      inv_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      z_q     <= z_d;
      op_q    <= op_d;
      inv_q   <= inv_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end

  // flag handshake misuse: first mid-operation, or a continuation slice while idle
  always_ff @(posedge i_alu_gck) begin
    if (!i_alu_rst && i_alu_vld) begin
      assert (first || !i_alu_first) else $error("idli_ser_alu_m: first slice while busy");
      assert (!first || i_alu_first) else $error("idli_ser_alu_m: slice dropped while idle");
    end
  end

  assign o_alu_vld   = vld_q;
  assign o_alu_last  = last_q;
  assign o_alu_data  = data_q;
  assign o_alu_flags = flags_q;
  assign o_alu_busy  = state_q == RUN;
endmodule

// File: tb/tb_idli_ser_alu_m.sv
// tb_idli_ser_alu_m: directed scoreboard bench for the serial ALU at three geometries
module tb_idli_ser_alu_m;
  import idli_ser_alu_pkg::*;

  typedef struct packed {
    logic [3:0] d;
    logic       l;
    logic [3:0] f;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_err = 0;
  int   n_chk = 0;
  logic mon_en = 1'b0;
  exp_t sb[$];
  exp_t me;

  always #5 clk = ~clk;

  logic vld0, first0, inv0, cin0, ovld0, olast0, obusy0;
  alu_op_t op0;
  logic [3:0] lhs0, rhs0, odata0, oflags0;

  logic vld1, first1, inv1, cin1, ovld1, olast1, obusy1;
  alu_op_t op1;
  logic [7:0] lhs1, rhs1, odata1;
  logic [3:0] oflags1;

  logic vld2, first2, inv2, cin2, ovld2, olast2, obusy2;
  alu_op_t op2;
  logic [3:0] lhs2, rhs2, odata2, oflags2;

  idli_ser_alu_m u0 (
    .i_alu_gck(clk), .i_alu_rst(rst), .i_alu_vld(vld0), .i_alu_first(first0),
    .i_alu_op(op0), .i_alu_rhs_inv(inv0), .i_alu_cin(cin0), .i_alu_lhs(lhs0),
    .i_alu_rhs(rhs0), .o_alu_vld(ovld0), .o_alu_last(olast0), .o_alu_data(odata0),
    .o_alu_flags(oflags0), .o_alu_busy(obusy0)
  );

  idli_ser_alu_m #(.SLICE_W(8), .WORD_W(32)) u1 (
    .i_alu_gck(clk), .i_alu_rst(rst), .i_alu_vld(vld1), .i_alu_first(first1),
    .i_alu_op(op1), .i_alu_rhs_inv(inv1), .i_alu_cin(cin1), .i_alu_lhs(lhs1),
    .i_alu_rhs(rhs1), .o_alu_vld(ovld1), .o_alu_last(olast1), .o_alu_data(odata1),
    .o_alu_flags(oflags1), .o_alu_busy(obusy1)
  );

  idli_ser_alu_m #(.SLICE_W(4), .WORD_W(4)) u2 (
    .i_alu_gck(clk), .i_alu_rst(rst), .i_alu_vld(vld2), .i_alu_first(first2),
    .i_alu_op(op2), .i_alu_rhs_inv(inv2), .i_alu_cin(cin2), .i_alu_lhs(lhs2),
    .i_alu_rhs(rhs2), .o_alu_vld(ovld2), .o_alu_last(olast2), .o_alu_data(odata2),
    .o_alu_flags(oflags2), .o_alu_busy(obusy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // word-level reference: returns {Z,N,C,V, result}
  function automatic logic [19:0] model(input alu_op_t op, input logic inv, input logic cin,
                                        input logic [15:0] a, input logic [15:0] b);
    logic [15:0] bb, r;
    logic [16:0] s;
    logic c, v;
    bb = inv ? ~b : b;
    s = {1'b0, a} + {1'b0, bb} + {16'd0, cin};
    c = 1'b0;
    v = 1'b0;
    case (op)
      ALU_ADD: begin
        r = s[15:0];
        c = s[16];
        v = (a[15] == bb[15]) && (r[15] != a[15]);
      end
      ALU_AND: r = a & bb;
      ALU_OR:  r = a | bb;
      default: r = a ^ bb;
    endcase
    return {r == 16'd0, r[15], c, v, r};
  endfunction

  task automatic do_op(input alu_op_t op, input logic inv, input logic cin,
                       input logic [15:0] a, input logic [15:0] b, input int gap, input int n);
    logic [19:0] m;
    exp_t e;
    m = model(op, inv, cin, a, b);
    for (int i = 0; i < n; i++) begin
      vld0 = 1'b1;
      first0 = (i == 0);
      op0 = op;
      inv0 = inv;
      cin0 = cin;
      lhs0 = a[4*i +: 4];
      rhs0 = b[4*i +: 4];
      e.d = m[4*i +: 4];
      e.l = (i == 3);
      e.f = m[19:16];
      sb.push_back(e);
      @(posedge clk); #1;
      vld0 = 1'b0;
      first0 = 1'b0;
      if (i == 0)
        repeat (gap) begin
          chk("busy_gap", {31'd0, obusy0}, 32'd1);
          @(posedge clk); #1;
        end
    end
    if (n == 4) chk("busy_end", {31'd0, obusy0}, 32'd0);
  endtask

  // scoreboard: every valid output slice must match the oldest expected slice
  always @(negedge clk) begin
    if (mon_en && ovld0) begin
      chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        me = sb.pop_front();
        chk("data", {28'd0, odata0}, {28'd0, me.d});
        chk("last", {31'd0, olast0}, {31'd0, me.l});
        if (me.l) chk("flags", {28'd0, oflags0}, {28'd0, me.f});
      end
    end
  end

  initial begin
    logic [31:0] a1, b1;
    rst = 1'b1;
    {vld0, first0, inv0, cin0, lhs0, rhs0} = '0;
    {vld1, first1, inv1, cin1, lhs1, rhs1} = '0;
    {vld2, first2, inv2, cin2, lhs2, rhs2} = '0;
    op0 = ALU_ADD;
    op1 = ALU_ADD;
    op2 = ALU_ADD;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {ovld0, olast0, odata0, oflags0, obusy0}, 32'd0);
    chk("rst_outs32", {ovld1, olast1, odata1, oflags1, obusy1}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    do_op(ALU_ADD, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 0, 4);
    do_op(ALU_ADD, 1'b1, 1'b1, 16'h1234, 16'h1234, 2, 4);
    do_op(ALU_AND, 1'b0, 1'b0, 16'hF0F0, 16'h0FF0, 0, 4);
    do_op(ALU_OR,  1'b0, 1'b0, 16'h00FF, 16'hFF00, 0, 4);
    do_op(ALU_XOR, 1'b0, 1'b0, 16'hA5C3, 16'h3C5A, 1, 4);
    do_op(ALU_ADD, 1'b1, 1'b1, 16'h0003, 16'h0005, 0, 4);

    do_op(ALU_ADD, 1'b0, 1'b0, 16'h1357, 16'h2468, 0, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_outs", {ovld0, olast0, odata0, oflags0, obusy0}, 32'd0);
    rst = 1'b0;
    do_op(ALU_ADD, 1'b0, 1'b0, 16'h0001, 16'h0001, 0, 4);
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    #1;
    chk("sb_drain", sb.size(), 32'd0);

    a1 = 32'hFFFF_FFFF;
    b1 = 32'h0000_0001;
    for (int i = 0; i < 4; i++) begin
      vld1 = 1'b1;
      first1 = (i == 0);
      op1 = ALU_ADD;
      lhs1 = a1[8*i +: 8];
      rhs1 = b1[8*i +: 8];
      @(posedge clk); #1;
      vld1 = 1'b0;
      first1 = 1'b0;
      chk("w32_vld", {31'd0, ovld1}, 32'd1);
      chk("w32_data", {24'd0, odata1}, 32'd0);
      chk("w32_last", {31'd0, olast1}, {31'd0, i == 3});
      chk("w32_busy", {31'd0, obusy1}, {31'd0, i != 3});
    end
    chk("w32_flags", {28'd0, oflags1}, 32'hA);

    vld2 = 1'b1;
    first2 = 1'b1;
    op2 = ALU_XOR;
    lhs2 = 4'hA;
    rhs2 = 4'hF;
    @(posedge clk); #1;
    vld2 = 1'b0;
    first2 = 1'b0;
    chk("w4_vld_last", {30'd0, ovld2, olast2}, 32'd3);
    chk("w4_data", {28'd0, odata2}, 32'h5);
    chk("w4_flags", {28'd0, oflags2}, 32'd0);
    chk("w4_busy", {31'd0, obusy2}, 32'd0);
    @(posedge clk); #1;
    chk("w4_vld_drop", {31'd0, ovld2}, 32'd0);
    chk("w4_flags_hold", {28'd0, oflags2}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/idli_ser_alu_m.md
Name: idli_ser_alu_m

Overview:
Parametrised multi-cycle serial ALU. It processes a WORD_W-bit operation as WORD_W/SLICE_W slices, least-significant slice first.
- Carry is kept in an internal register between slices.
- Word-level Z/N/C/V flags are accumulated across slices.
- Slices are accepted through a valid-qualified handshake, so operand delivery may stall.
- Sits between the register-file/SQI operand stream and writeback, replacing the fixed 4b combinational slice ALU.

Parameters:
SLICE_W, 4, bits processed per accepted slice; must be ≥1.
WORD_W, 16, total operation width; WORD_W % SLICE_W == 0 required (elaboration-time assertion).
NSLICE, WORD_W/SLICE_W (derived localparam), slices per operation; must be ≥1.

Ports:
i_alu_gck  in  1  clock.
i_alu_rst  in  1  synchronous, active-high reset.
i_alu_vld  in  1  slice valid; lhs/rhs slice is consumed on every cycle it is high.
i_alu_first  in  1  marks first slice of an operation; only meaningful with i_alu_vld.
i_alu_op  in  alu_op_t  ADD/AND/OR/XOR; sampled on the first slice, held internally.
i_alu_rhs_inv  in  1  invert RHS for the whole operation; sampled on the first slice.
i_alu_cin  in  1  carry into slice 0; sampled on the first slice.
i_alu_lhs  in  SLICE_W  LHS slice.
i_alu_rhs  in  SLICE_W  RHS slice.
o_alu_vld  out  1  registered result slice valid.
o_alu_last  out  1  high with o_alu_vld on the final slice.
o_alu_data  out  SLICE_W  registered result slice.
o_alu_flags  out  4  {Z,N,C,V}; valid when o_alu_last is high, held until the next o_alu_last.
o_alu_busy  out  1  high while an operation is mid-flight (state RUN).

Behaviour:
- Reset: o_alu_vld=0, o_alu_last=0, o_alu_data=0, o_alu_flags=0, o_alu_busy=0.
  - Internal state: state=IDLE, slice counter=0, carry=0, zero-accumulator=1.
- States:
  - IDLE: waits for i_alu_vld & i_alu_first.
  - RUN: one or more slices consumed, final slice not yet consumed.
- Accepting the first slice:
  - Latch op and rhs_inv.
  - Slice carry-in = i_alu_cin.
  - Counter←1.
  - If NSLICE==1, stay in IDLE; otherwise go to RUN.
- In RUN, each i_alu_vld cycle:
  - Slice carry-in = carry register.
  - Counter increments.
  - On the slice with counter==NSLICE-1: return to IDLE, counter←0.
- Cycles with i_alu_vld=0 in RUN: no state change; carry, counter and flag accumulators all hold (stall).
- i_alu_first asserted in RUN: protocol error. It is ignored; the slice is treated as a continuation. Simulation assertion fires.
- i_alu_vld without i_alu_first in IDLE: slice is dropped, no output. Simulation assertion fires.
- Per-slice datapath (combinational, bitwise over SLICE_W):
  - rhs' = rhs_inv ? ~rhs : rhs.
  - AND = lhs&rhs'; OR = lhs|rhs'; XOR = lhs^rhs'.
  - ADD = ripple of XOR/AND with the slice carry-in.
  - Carry register updates on every accepted slice for ADD. For logic ops it is forced to 0.
- Latency: result of a slice accepted in cycle t appears on o_alu_data with o_alu_vld=1 in cycle t+1. Back-to-back operations run at full rate with no bubble.
- Flags, registered and updated only with the last slice:
  - Z = all result bits of every slice are zero.
  - N = MSB of the last result slice.
  - C = carry out of the last slice (ADD only; 0 for logic ops).
  - V = carry into the MSB XOR carry out of the MSB of the last slice (ADD only; else 0).
- Subtract = ADD with rhs_inv=1 and cin=1. C=1 means no borrow.
- Reset asserted mid-operation: abort immediately. Next cycle matches the reset values, and no o_alu_last is produced for the aborted operation.
- o_alu_vld/o_alu_last/o_alu_data are registered outputs. They deassert the cycle after a non-consumed input cycle.

Test Plan:
- Default params, ADD 0x7FFF+0x0001, cin=0, 4 consecutive vld slices -> o_alu_data slices F→0,F→0,F→0,7→8, i.e. word 0x8000. o_alu_last on 4th output; flags Z=0,N=1,C=0,V=1.
- SUB 0x1234-0x1234 (rhs_inv=1, cin=1) with vld low for 2 cycles between slices 1 and 2 -> result 0x0000, Z=1,N=0,C=1,V=0. Outputs only on consumed cycles; busy high throughout the gap.
- AND 0xF0F0 & 0x0FF0 immediately followed (no bubble) by OR 0x00FF | 0xFF00 -> 0x00F0 (Z=0,N=0,C=0,V=0), then 0xFFFF (N=1, C=0, V=0). The two operations are contiguous on the output.
- Reset asserted after 2 slices of an ADD, then a fresh ADD 0x0001+0x0001 -> no o_alu_last for the aborted op, all outputs 0 the cycle after reset, new result 0x0002 with clean carry.
- WORD_W=32, SLICE_W=8: ADD 0xFFFFFFFF+0x00000001 -> 0x00000000, Z=1,C=1,V=0. o_alu_last on 4th slice.
- WORD_W=SLICE_W=4: XOR 0xA^0xF -> 0x5 with o_alu_vld and o_alu_last together one cycle later; busy never asserts.
